// File: rtl/ones_count_pkg.sv
// Shared types and default sizing for the round-robin ones-count scheduler.
package ones_count_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 8;
   localparam int unsigned DEF_COUNT_WIDTH = 4;
   localparam int unsigned DEF_NUM_REQ     = 4;
   localparam int unsigned DEF_ID_WIDTH    = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/ones_count_serial.sv
// Serial population counter: shifts a loaded word right one bit per step,
// accumulating the bits shifted out.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   load, data_in  - capture data_in into the shift register and clear count
//   step           - add shift register LSB to count, shift right by one
//   zero           - shift register is all zeros (no more ones to count)
//   count          - running number of ones counted
module ones_count_serial
   import ones_count_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   step,
   input  logic [DATA_WIDTH-1:0]  data_in,
   output logic                   zero,
   output logic [COUNT_WIDTH-1:0] count
);

   logic [DATA_WIDTH-1:0]  sr_q;
   logic [COUNT_WIDTH-1:0] count_q;

   // Shift register and accumulator; load has priority over step.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q    <= '0;
         count_q <= '0;
      end else if (load) begin
         sr_q    <= data_in;
         count_q <= '0;
      end else if (step) begin
         sr_q    <= sr_q >> 1;
         count_q <= count_q + COUNT_WIDTH'(sr_q[0]);
      end
   end

   assign zero  = (sr_q == '0);
   assign count = count_q;

endmodule

// File: rtl/ones_count_sched.sv
// Round-robin scheduler that grants one requester at a time, counts the ones
// in its data word serially, and reports the result with a one-cycle done.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   req        - level request per requester
//   data       - packed requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        - one-hot, one-cycle grant pulse (first SHIFT cycle)
//   busy       - operation in progress (state not IDLE)
//   done       - one-cycle result-valid pulse
//   done_id    - requester index for the result on bit_count
//   bit_count  - number of ones in the granted word, held until next done
module ones_count_sched
   import ones_count_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
   parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
   parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          busy,
   output logic                          done,
   output logic [ID_WIDTH-1:0]           done_id,
   output logic [COUNT_WIDTH-1:0]        bit_count
);

   state_e                 state_q, state_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [ID_WIDTH-1:0]    done_id_q, done_id_d;
   logic [COUNT_WIDTH-1:0] bit_count_q, bit_count_d;
   logic [ID_WIDTH-1:0]    last_id_q, last_id_d;

   logic                   rr_found;
   logic [ID_WIDTH-1:0]    rr_sel;
   int unsigned            rr_idx;

   logic                   ser_load;
   logic                   ser_step;
   logic                   ser_zero;
   logic [COUNT_WIDTH-1:0] ser_count;
   logic [DATA_WIDTH-1:0]  sel_data;

   // Round-robin search starting just after the last granted index.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = '0;
      rr_idx   = 0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         rr_idx = (32'(last_id_q) + off) % NUM_REQ;
         if (!rr_found && req[ID_WIDTH'(rr_idx)]) begin
            rr_found = 1'b1;
            rr_sel   = ID_WIDTH'(rr_idx);
         end
      end
   end

   assign sel_data = data[32'(rr_sel)*DATA_WIDTH +: DATA_WIDTH];

   ones_count_serial #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_serial (
      .clk     (clk),
      .reset   (reset),
      .load    (ser_load),
      .step    (ser_step),
      .data_in (sel_data),
      .zero    (ser_zero),
      .count   (ser_count)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         bit_count_q <= '0;
         last_id_q   <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         bit_count_q <= bit_count_d;
         last_id_q   <= last_id_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      gnt_d       = '0;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      bit_count_d = bit_count_q;
      last_id_d   = last_id_q;
      ser_load    = 1'b0;
      ser_step    = 1'b0;

      case (state_q)
         IDLE: begin
            if (rr_found) begin
               ser_load  = 1'b1;
               gnt_d     = NUM_REQ'(1) << rr_sel;
               last_id_d = rr_sel;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Count is final once the remaining word is empty; latch it here
            // so done and the result appear together in DONE.
            if (ser_zero) begin
               state_d     = DONE;
               done_d      = 1'b1;
               bit_count_d = ser_count;
               done_id_d   = last_id_q;
            end else begin
               ser_step = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign bit_count = bit_count_q;

endmodule

// File: tb/tb_ones_count_sched.sv
// Directed self-checking bench for ones_count_sched.
module tb_ones_count_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic [1:0]  done_id;
   logic [3:0]  bit_count;

   int n_checks = 0;
   int n_fail   = 0;

   ones_count_sched dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .data      (data),
      .gnt       (gnt),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .bit_count (bit_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; leaves the bench at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Step until gnt is seen; n returns the number of cycles taken.
   task automatic wait_gnt(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt == 4'b0 && n < 30);
      chk(tag, 32'(gnt != 4'b0), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 30) begin
         tick();
         n++;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      req   = '0;
      data  = '0;
      @(negedge clk);
      do_reset();

      // Reset state.
      chk("rst_gnt",   32'(gnt),       32'h0);
      chk("rst_busy",  32'(busy),      32'h0);
      chk("rst_done",  32'(done),      32'h0);
      chk("rst_count", 32'(bit_count), 32'h0);
      chk("rst_id",    32'(done_id),   32'h0);

      // Requester 0, 8'h0F: grant cycle 1, done cycle 6, count 4.
      req = 4'b0001; data[7:0] = 8'h0F;
      tick();
      chk("s1_gnt",  32'(gnt),  32'h1);
      chk("s1_busy", 32'(busy), 32'h1);
      req = '0;
      repeat (4) tick();
      chk("s1_done_c5", 32'(done), 32'h0);
      tick();
      chk("s1_done_c6", 32'(done),      32'h1);
      chk("s1_count",   32'(bit_count), 32'd4);
      chk("s1_id",      32'(done_id),   32'd0);
      tick();
      chk("s1_done_off", 32'(done),      32'h0);
      chk("s1_idle",     32'(busy),      32'h0);
      chk("s1_hold",     32'(bit_count), 32'd4);

      // Requester 2, zero data: done in cycle 2.
      req = 4'b0100; data[23:16] = 8'h00;
      tick();
      chk("s2_gnt", 32'(gnt), 32'h4);
      req = '0;
      tick();
      chk("s2_done",  32'(done),      32'h1);
      chk("s2_count", 32'(bit_count), 32'd0);
      chk("s2_id",    32'(done_id),   32'd2);
      tick();

      // Requester 1, 8'hFF: busy cycles 1-10, done cycle 10, count 8.
      req = 4'b0010; data[15:8] = 8'hFF;
      tick();
      chk("s3_gnt", 32'(gnt), 32'h2);
      req = '0;
      for (int c = 1; c <= 10; c++) begin
         chk($sformatf("s3_busy_c%0d", c), 32'(busy), 32'h1);
         chk($sformatf("s3_done_c%0d", c), 32'(done), 32'(c == 10));
         if (c < 10) tick();
      end
      chk("s3_count", 32'(bit_count), 32'd8);
      chk("s3_id",    32'(done_id),   32'd1);
      tick();
      chk("s3_idle", 32'(busy), 32'h0);

      // Requesters 0 and 2 held: grants alternate 0,2,0,2.
      do_reset();
      data[7:0] = 8'h01; data[23:16] = 8'h03;
      req = 4'b0101;
      for (int t = 0; t < 4; t++) begin
         wait_gnt($sformatf("s4_gnt_seen%0d", t), n);
         if (t > 0) chk($sformatf("s4_gap%0d", t), 32'(n), 32'd2);
         chk($sformatf("s4_gnt%0d", t), 32'(gnt), (t % 2 == 0) ? 32'h1 : 32'h4);
         wait_done($sformatf("s4_done%0d", t));
         chk($sformatf("s4_count%0d", t), 32'(bit_count), (t % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("s4_id%0d", t),    32'(done_id),   (t % 2 == 0) ? 32'd0 : 32'd2);
      end
      req = '0;
      tick();

      // Reset in cycle 4 while counting 8'h80 aborts the operation.
      req = 4'b0001; data[7:0] = 8'h80;
      tick();
      chk("s5_gnt", 32'(gnt), 32'h1);
      req = '0;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("s5_busy",  32'(busy),      32'h0);
      chk("s5_done",  32'(done),      32'h0);
      chk("s5_count", 32'(bit_count), 32'h0);
      req = 4'b1000; data[31:24] = 8'h5A;
      tick();
      chk("s5_gnt3", 32'(gnt), 32'h8);
      req = '0;
      wait_done("s5_done3");
      chk("s5_id",    32'(done_id),   32'd3);
      chk("s5_count3", 32'(bit_count), 32'd4);
      tick();

      // All requesting, each drops after grant: order 0,1,2,3 back to back.
      do_reset();
      data = {8'h00, 8'h07, 8'h03, 8'h01};
      req  = 4'b1111;
      for (int t = 0; t < 4; t++) begin
         wait_gnt($sformatf("s6_gnt_seen%0d", t), n);
         if (t > 0) chk($sformatf("s6_gap%0d", t), 32'(n), 32'd2);
         chk($sformatf("s6_gnt%0d", t), 32'(gnt), 32'h1 << t);
         req[t] = 1'b0;
         wait_done($sformatf("s6_done%0d", t));
         chk($sformatf("s6_id%0d", t),    32'(done_id),   32'(t));
         chk($sformatf("s6_count%0d", t), 32'(bit_count), (t == 3) ? 32'd0 : 32'(t + 1));
      end
      tick();
      chk("s6_idle", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ones_count_sched.md
ONES_COUNT_SCHED -- requirements
Module: ones_count_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each requester's data word.
REQ-002 SHALL have parameter COUNT_WIDTH, default 4, result width; SHALL be at least clog2(DATA_WIDTH+1).
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-004 SHALL have parameter ID_WIDTH, default 2, equal to clog2(NUM_REQ).
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1; reset is synchronous, active-high; clock is clk.
REQ-007 SHALL have port req, input, NUM_REQ, level request per requester.
REQ-008 SHALL have port data, input, NUM_REQ*DATA_WIDTH, requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port gnt, output, NUM_REQ, one-hot, registered, 1-cycle grant pulse.
REQ-010 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-011 SHALL have port done, output, 1, 1-cycle result-valid pulse.
REQ-012 SHALL have port done_id, output, ID_WIDTH, index of the requester whose result is on bit_count.
REQ-013 SHALL have port bit_count, output, COUNT_WIDTH, number of 1 bits in the granted word.

Function
REQ-014 FSM SHALL have states IDLE, SHIFT, DONE.
REQ-015 IDLE: if any req bit is high, SHALL select one round-robin, load its data into the shift register, clear the counter, set gnt for that index, and enter SHIFT on the same edge; otherwise SHALL remain in IDLE.
REQ-016 Round-robin search SHALL start at last_id+1 and wrap modulo NUM_REQ; last_id SHALL update to the granted index on every grant.
REQ-017 gnt SHALL be high only in the first SHIFT cycle; requester SHALL drop req after seeing gnt; req SHALL be ignored outside IDLE.
REQ-018 SHIFT: if the shift register is nonzero, SHALL add its LSB to the counter and shift right by 1; if zero, SHALL enter DONE without counting.
REQ-019 DONE: done=1, bit_count=counter, done_id=granted index for exactly one cycle; SHALL then return to IDLE.
REQ-020 Latency, with cycle 0 the IDLE cycle that samples req and k the index of the highest set bit: done SHALL occur in cycle k+3; for zero data, in cycle 2; worst case DATA_WIDTH+2.
REQ-021 bit_count and done_id SHALL hold their values until the next DONE.
REQ-022 Counter SHALL not wrap: an all-ones word SHALL yield DATA_WIDTH.
REQ-023 A request held through DONE SHALL be re-arbitrated in the next IDLE cycle under round-robin, with no priority kept.

Reset
REQ-024 reset SHALL force state IDLE and clear gnt, done, busy, bit_count, done_id, the counter and the shift register, and SHALL set last_id to NUM_REQ-1 so that req[0] has first priority.
REQ-025 reset asserted in SHIFT or DONE SHALL abort the operation: no done pulse, busy low in the cycle after reset is sampled.

Structure
REQ-026 Package ones_count_pkg SHALL hold the state enum and the default DATA_WIDTH, COUNT_WIDTH and NUM_REQ constants.
REQ-027 Sub-module ones_count_serial SHALL contain the shift register and counter, with controls load and step, status zero, and output count; ones_count_sched SHALL contain the arbiter and the FSM.

Verification
REQ-028 Scenario: reset, then req=4'b0001 with data0=8'h0F -> gnt=4'b0001 in cycle 1, done in cycle 6, bit_count=4, done_id=0.
REQ-029 Scenario: req[2] with data2=8'h00 -> done in cycle 2, bit_count=0, done_id=2.
REQ-030 Scenario: req[1] with data1=8'hFF -> done in cycle 10, bit_count=8 (no wrap), busy high for cycles 1-10.
REQ-031 Scenario: req[0] and req[2] held continuously with data 8'h01 and 8'h03 -> grants alternate 0,2,0,2; bit_count alternates 1,2.
REQ-032 Scenario: reset pulsed in cycle 4 while processing 8'h80 -> no done, busy=0 in cycle 5; a subsequent req=4'b1000 is granted with done_id=3.
REQ-033 Scenario: all req bits high and each dropped after its grant -> grant order 0,1,2,3, with a new grant in the IDLE cycle immediately following each DONE.
